ifu_prefetch: RTL and testbench
===============================

Name: ifu_prefetch

Overview:
- Instruction fetch unit sitting directly upstream of the IF/ID pipeline register.
- Generates the PC and issues word fetches on a req/gnt/rvalid instruction bus.
- Buffers returned words in a small in-order prefetch FIFO and presents the head word plus its address to IF/ID.
- Handles jump redirect, hold, and debug halt, and discards stale in-flight responses after a redirect.

Parameters:
- RESET_ADDR, 32'h0000_0000, PC loaded on reset.
- DEPTH, 4, prefetch FIFO entries; power of two, 2..8.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered bus requests; 1..DEPTH.

Ports:
- clk  in  1  core clock; all state changes on its rising edge.
- rst  in  1  synchronous reset, active-high.
- jump_flag_i  in  1  redirect request from EX (jump, branch or interrupt vector).
- jump_addr_i  in  32  redirect target; word aligned.
- hold_flag_i  in  1  downstream stall; head entry is not consumed.
- dm_halt_req_i  in  1  debug halt request.
- ibus_req_o  out  1  fetch request.
- ibus_addr_o  out  32  fetch address; equals the PC register.
- ibus_gnt_i  in  1  request accepted this cycle.
- ibus_rvalid_i  in  1  response valid; responses return in order, at least 1 cycle after grant.
- ibus_rdata_i  in  32  response data.
- inst_o  out  32  head instruction; 32'h0000_0013 (NOP) when empty.
- inst_addr_o  out  32  head address; 0 when empty.
- inst_valid_o  out  1  FIFO non-empty, or bypass hit.

Behaviour:
- Reset state: pc=RESET_ADDR; FIFO empty; outstanding=0; discard=0; state=BOOT. Reset values: ibus_req_o=0, inst_valid_o=0, inst_o=NOP, inst_addr_o=0. Reset mid-transfer drops all state; late rvalids arriving after reset are ignored.
- States:
  - BOOT: lasts 1 cycle, then RUN.
  - RUN: normal fetching.
  - DRAIN: discard>0 after a redirect; goes to RUN when discard reaches 0.
  - HALT: entered while dm_halt_req_i=1; returns to RUN, or to DRAIN if discard>0, when it deasserts.
- Request enable: ibus_req_o=1 only when all of the following hold:
  - state is RUN;
  - jump_flag_i=0 and dm_halt_req_i=0;
  - outstanding<MAX_OUTSTANDING;
  - outstanding+fifo_count<DEPTH.
  This credit rule guarantees the FIFO never overflows.
- Grant: on ibus_req_o & ibus_gnt_i, pc<=pc+4 (32-bit wrap) and outstanding increments. A grant and an rvalid in the same cycle leave outstanding unchanged.
- Response: on ibus_rvalid_i with discard=0, push {rdata, address}. The address is tracked by a per-slot address queue of MAX_OUTSTANDING entries written at grant time.
- Pop: when inst_valid_o=1, hold_flag_i=0, dm_halt_req_i=0 and jump_flag_i=0. A push and a pop in the same cycle are both performed; the count is unchanged.
- Redirect (jump_flag_i=1):
  - pc<=jump_addr_i; FIFO cleared; no pop.
  - ibus_req_o forced to 0 that cycle.
  - Any rvalid in that cycle is dropped.
  - discard<=outstanding, minus 1 if rvalid in that cycle. State goes to DRAIN if discard>0, else RUN.
- Redirect during DRAIN: discard is recomputed by the same rule; the old count plus still-outstanding requests are all covered because discard equals outstanding.
- Halt: new requests stop and no pops occur; in-flight responses still land (or are discarded) normally. jump_flag_i has priority over dm_halt_req_i for pc and FIFO updates.
- Latency: grant at cycle N, rvalid at N+k, inst_valid_o=1 at N+k+1 (FIFO registered).

Optional Feature:
- IFU_BYPASS_EN.
  - Defined: when the FIFO is empty, discard=0, rvalid=1 and the pop condition holds, the response drives inst_o/inst_addr_o/inst_valid_o combinationally in that same cycle and is not written to the FIFO. Latency is N+k.
  - Undefined: every response passes through the FIFO; latency is N+k+1.

Test Plan:
- Reset with RESET_ADDR=0x80; gnt tied 1, rvalid 1 cycle after grant -> ibus_addr_o sequence 0x80,0x84,0x88; inst_addr_o 0x80 first valid (+1 cycle without IFU_BYPASS_EN).
- hold_flag_i=1 for 10 cycles -> FIFO fills to DEPTH=4, ibus_req_o drops, no overflow; on release, 4 entries pop in address order.
- 2 requests outstanding, jump_flag_i=1 with jump_addr_i=0x200 -> next 2 rvalids discarded (inst_valid_o stays 0), first valid inst_addr_o=0x200.
- jump_flag_i asserted in the same cycle as an rvalid with outstanding=1 -> discard=0, state RUN, that word never appears.
- dm_halt_req_i=1 for 5 cycles -> ibus_req_o=0, head stays; release -> fetch resumes at the saved PC with no duplicated or skipped address.
- PC at 0xFFFF_FFFC -> next fetch address 0x0000_0000.

Source files
------------

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: PC generation, req/gnt/rvalid word fetch and in-order prefetch FIFO to IF/ID.
// Define IFU_BYPASS_EN to forward a response straight to IF/ID when the FIFO is empty.
module ifu_prefetch #(
  parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  input  logic        dm_halt_req_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT, RUN, DRAIN, HALT} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   fifo_data_q [DEPTH];
  logic [31:0]   fifo_addr_q [DEPTH];
  logic [31:0]   aq_q [MAX_OUTSTANDING];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [QW-1:0] aq_rd_q, aq_rd_d, aq_wr_q, aq_wr_d;
  logic [CW-1:0] count_q, count_d, out_q, out_d, discard_q, discard_d;
  logic          grant, rvalid, push, pop, pop_ok, bypass_hit;

  function automatic logic [QW-1:0] aq_inc(input logic [QW-1:0] p);
    return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + QW'(1);
  endfunction

  // Bus handshake, FIFO control and IF/ID head presentation
  always_comb begin
    ibus_req_o   = 1'b0;
    inst_o       = NOP;
    inst_addr_o  = '0;
    inst_valid_o = 1'b0;
    // rvalid with nothing outstanding is a leftover from before reset
    rvalid = ibus_rvalid_i && (out_q != '0);
    pop_ok = !hold_flag_i && !dm_halt_req_i && !jump_flag_i;
    if ((state_q == RUN) && !jump_flag_i && !dm_halt_req_i
        && (out_q < CW'(MAX_OUTSTANDING))
        && (((CW+1)'(out_q) + (CW+1)'(count_q)) < (CW+1)'(DEPTH))) begin
      ibus_req_o = 1'b1;
    end
    grant = ibus_req_o && ibus_gnt_i;
`ifdef IFU_BYPASS_EN
    bypass_hit = (count_q == '0) && (discard_q == '0) && rvalid && pop_ok;
`else
    bypass_hit = 1'b0;
`endif
    push = rvalid && (discard_q == '0) && !jump_flag_i && !bypass_hit;
    pop  = (count_q != '0) && pop_ok;
    if (count_q != '0) begin
      inst_o       = fifo_data_q[rd_ptr_q];
      inst_addr_o  = fifo_addr_q[rd_ptr_q];
      inst_valid_o = 1'b1;
    end else if (bypass_hit) begin
      inst_o       = ibus_rdata_i;
      inst_addr_o  = aq_q[aq_rd_q];
      inst_valid_o = 1'b1;
    end
  end

  assign ibus_addr_o = pc_q;

  // Next-state for PC, counters, pointers and FSM
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    discard_d = discard_q;
    aq_rd_d   = rvalid ? aq_inc(aq_rd_q) : aq_rd_q;
    aq_wr_d   = grant ? aq_inc(aq_wr_q) : aq_wr_q;
    out_d     = out_q + CW'(grant) - CW'(rvalid);

    if (jump_flag_i) begin
      pc_d      = jump_addr_i;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      // every request still in flight after this edge belongs to the old path
      discard_d = out_q - CW'(rvalid);
    end else begin
      if (grant) pc_d = pc_q + 32'd4;
      if (rvalid && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end

    case (state_q)
      BOOT:    state_d = RUN;
      default: begin
        if (dm_halt_req_i)         state_d = HALT;
        else if (discard_d != '0) state_d = DRAIN;
        else                       state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BOOT;
      pc_q      <= RESET_ADDR;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      out_q     <= '0;
      discard_q <= '0;
      aq_rd_q   <= '0;
      aq_wr_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      out_q     <= out_d;
      discard_q <= discard_d;
      aq_rd_q   <= aq_rd_d;
      aq_wr_q   <= aq_wr_d;
    end
  end

  // Payload storage; validity is tracked by the reset counters above
  always_ff @(posedge clk) begin
    if (grant) aq_q[aq_wr_q] <= pc_q;
    if (push) begin
      fifo_data_q[wr_ptr_q] <= ibus_rdata_i;
      fifo_addr_q[wr_ptr_q] <= aq_q[aq_rd_q];
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomized bench for ifu_prefetch: bus slave model plus a queue-based model of the fetch stream.
module tb_ifu_prefetch;
  localparam logic [31:0] RST_PC = 32'h0000_0080;
  localparam int          DEPTH  = 4;
  localparam int          MAXO   = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_i, hold_flag_i, dm_halt_req_i;
  logic [31:0] jump_addr_i;
  logic        ibus_req_o, ibus_gnt_i, ibus_rvalid_i;
  logic [31:0] ibus_addr_o, ibus_rdata_i;
  logic [31:0] inst_o, inst_addr_o;
  logic        inst_valid_o;

  ifu_prefetch #(.RESET_ADDR(RST_PC), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .hold_flag_i(hold_flag_i), .dm_halt_req_i(dm_halt_req_i),
    .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o), .ibus_gnt_i(ibus_gnt_i),
    .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o)
  );

  always #5 clk = ~clk;

  int n_tests, n_fail;

  // reference model: fetch PC, in-flight requests (stale after redirect), buffered words
  logic [31:0] m_pc;
  logic [31:0] iq_addr[$];
  bit          iq_stale[$];
  logic [31:0] avail[$];
  int          since_rst;
  bit          halt_prev;

  // bus slave
  logic [31:0] sq_addr[$];
  int          sq_ready[$];
  int          cyc, gnt_pct, rv_pct, lat_min, lat_max, halt_left;
  bit          zombie;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic cycle(input bit hold, input bit halt, input int jmode, input logic [31:0] jaddr);
    bit rv, jmp, exp_req, byp, grant, pop_ok, rv_eff, s, exp_valid;
    int stale;
    logic [31:0] a, exp_inst, exp_iaddr;
    rv = 1'b0;
    if (zombie) rv = 1'b1;
    else if (sq_addr.size() > 0 && sq_ready[0] <= cyc && $urandom_range(99) < 32'(rv_pct)) rv = 1'b1;
    jmp = (jmode == 1) || (jmode == 2 && rv && iq_addr.size() == 1);
    ibus_gnt_i    = ($urandom_range(99) < 32'(gnt_pct));
    ibus_rvalid_i = rv;
    ibus_rdata_i  = $urandom;
    if (rv && !zombie) ibus_rdata_i = data_of(sq_addr[0]);
    hold_flag_i   = hold;
    dm_halt_req_i = halt;
    jump_flag_i   = jmp;
    jump_addr_i   = jaddr;

    @(negedge clk);
    stale = 0;
    foreach (iq_stale[i]) if (iq_stale[i]) stale++;
    rv_eff  = rv && iq_addr.size() > 0;
    pop_ok  = !hold && !halt && !jmp;
    exp_req = since_rst >= 1 && !halt_prev && stale == 0 && !jmp && !halt
              && iq_addr.size() < MAXO && iq_addr.size() + avail.size() < DEPTH;
`ifdef IFU_BYPASS_EN
    byp = avail.size() == 0 && stale == 0 && rv_eff && pop_ok;
`else
    byp = 1'b0;
`endif
    exp_valid = 1'b0; exp_inst = NOP; exp_iaddr = '0;
    if (avail.size() > 0) begin
      exp_valid = 1'b1; exp_inst = data_of(avail[0]); exp_iaddr = avail[0];
    end else if (byp) begin
      exp_valid = 1'b1; exp_inst = data_of(iq_addr[0]); exp_iaddr = iq_addr[0];
    end
    check("ibus_req", 32'(ibus_req_o), 32'(exp_req));
    check("ibus_addr", ibus_addr_o, m_pc);
    check("inst_valid", 32'(inst_valid_o), 32'(exp_valid));
    check("inst", inst_o, exp_inst);
    check("inst_addr", inst_addr_o, exp_iaddr);

    grant = exp_req && ibus_gnt_i;
    if (avail.size() > 0 && pop_ok) void'(avail.pop_front());
    if (rv_eff) begin
      a = iq_addr.pop_front();
      s = iq_stale.pop_front();
      if (!s && !jmp && !byp) avail.push_back(a);
    end
    if (jmp) begin
      avail.delete();
      foreach (iq_stale[i]) iq_stale[i] = 1'b1;
      m_pc = jaddr;
    end
    if (grant) begin
      iq_addr.push_back(m_pc);
      iq_stale.push_back(1'b0);
      sq_addr.push_back(m_pc);
      sq_ready.push_back(cyc + lat_min + int'($urandom_range(32'(lat_max - lat_min))));
      m_pc = m_pc + 32'd4;
    end
    if (rv && !zombie) begin
      void'(sq_addr.pop_front());
      void'(sq_ready.pop_front());
    end
    zombie    = 1'b0;
    halt_prev = halt && since_rst >= 1;
    since_rst++;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    jump_flag_i = 1'b0; hold_flag_i = 1'b0; dm_halt_req_i = 1'b0; jump_addr_i = '0;
    for (int i = 0; i < 3; i++) begin
      ibus_gnt_i    = 1'($urandom_range(1));
      ibus_rvalid_i = 1'($urandom_range(1));
      ibus_rdata_i  = $urandom;
      @(posedge clk);
      #1;
      check("rst_req", 32'(ibus_req_o), 32'd0);
      check("rst_valid", 32'(inst_valid_o), 32'd0);
      check("rst_inst", inst_o, NOP);
      check("rst_iaddr", inst_addr_o, 32'd0);
      check("rst_pc", ibus_addr_o, RST_PC);
    end
    rst = 1'b0;
    m_pc = RST_PC;
    iq_addr.delete(); iq_stale.delete(); avail.delete();
    sq_addr.delete(); sq_ready.delete();
    since_rst = 0; halt_prev = 1'b0;
    zombie = 1'b1;
  endtask

  task automatic random_phase(input int n);
    logic [31:0] ja;
    int jm;
    for (int i = 0; i < n; i++) begin
      if (halt_left == 0 && $urandom_range(99) < 2) halt_left = int'($urandom_range(6, 1));
      ja = ($urandom_range(9) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(3) << 2)
                                    : ($urandom & 32'hFFFF_FFFC);
      jm = ($urandom_range(99) < 3) ? 1 : (($urandom_range(99) < 10) ? 2 : 0);
      cycle($urandom_range(99) < 25, halt_left > 0, jm, ja);
      if (halt_left > 0) halt_left--;
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; zombie = 1'b0; halt_left = 0;
    gnt_pct = 100; rv_pct = 100; lat_min = 1; lat_max = 1;
    rst = 1'b1; ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = '0;
    do_reset();

    // streaming: gnt tied high, one-cycle response latency
    repeat (20) cycle(1'b0, 1'b0, 0, 32'd0);
    // hold fills the FIFO, then release drains in order
    repeat (10) cycle(1'b1, 1'b0, 0, 32'd0);
    repeat (10) cycle(1'b0, 1'b0, 0, 32'd0);
    // redirect with two requests in flight
    lat_min = 3; lat_max = 3;
    repeat (6) cycle(1'b0, 1'b0, 0, 32'd0);
    cycle(1'b0, 1'b0, 1, 32'h0000_0200);
    repeat (15) cycle(1'b0, 1'b0, 0, 32'd0);
    // redirect coincident with the last outstanding response
    gnt_pct = 30; lat_min = 1; lat_max = 2;
    for (int i = 0; i < 60; i++) cycle(1'b0, 1'b0, 2, 32'h0000_1000 + 32'(i * 64));
    // debug halt for five cycles
    gnt_pct = 100;
    repeat (8) cycle(1'b0, 1'b0, 0, 32'd0);
    repeat (5) cycle(1'b0, 1'b1, 0, 32'd0);
    repeat (10) cycle(1'b0, 1'b0, 0, 32'd0);
    // PC wrap-around
    cycle(1'b0, 1'b0, 1, 32'hFFFF_FFF8);
    repeat (12) cycle(1'b0, 1'b0, 0, 32'd0);
    // random traffic, then reset in the middle of it
    gnt_pct = 70; rv_pct = 70; lat_min = 1; lat_max = 4;
    random_phase(1500);
    do_reset();
    random_phase(500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
